// File: rtl/rv32i_ifetch.sv
// rtl/rv32i_ifetch.sv - rv32i instruction fetch/prefetch stage with redirect flush
// Optional performance counters are enabled by defining IFETCH_PERF_EN.
module rv32i_ifetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   pc_mem_q   [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];

    logic [CW:0]   occupancy;
    logic          issue;
    logic          drop;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_word;
    logic          unused_redirect_lsb;

    assign redirect_word       = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Credit counts both buffered and outstanding words, so every response has a slot.
    assign occupancy = {1'b0, inflight_q} + {1'b0, count_q};
    assign imem_req  = !rst && !redirect_valid && (occupancy < (CW + 1)'(DEPTH));
    assign imem_addr = fetch_pc_q;

    assign issue = imem_req && imem_gnt;
    assign drop  = imem_rvalid && (redirect_valid || (discard_q != '0));
    assign push  = imem_rvalid && !drop;
    assign pop   = instr_valid && instr_ready && !redirect_valid;

    assign instr_valid = (count_q != '0);
    assign instr       = data_mem_q[rd_ptr_q];
    assign instr_pc    = pc_mem_q[rd_ptr_q];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        discard_d  = discard_q;
        inflight_d = inflight_q + CW'(issue) - CW'(imem_rvalid);

        if (redirect_valid) begin
            fetch_pc_d = redirect_word;
            resp_pc_d  = redirect_word;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            discard_d  = inflight_d;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (imem_rvalid && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wr_ptr_d  = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            if (push) begin
                pc_mem_q[wr_ptr_q]   <= resp_pc_q;
                data_mem_q[wr_ptr_q] <= imem_rdata;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(push && (count_q == CW'(DEPTH))))
                else $fatal(1, "rv32i_ifetch: response pushed into full prefetch FIFO");
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_q + 32'(issue);
            perf_stall_q <= perf_stall_q + 32'(instr_ready && !instr_valid && !redirect_valid);
            perf_flush_q <= perf_flush_q + 32'(drop);
        end
    end
`endif

endmodule

// File: doc/rv32i_ifetch.md
Name: rv32i_ifetch

Overview:
Instruction fetch and prefetch stage that sits directly upstream of the rv32i core's instruction input.
- Issues sequential word fetches to instruction memory over a req/gnt + rvalid bus.
- Buffers returned words in a small FIFO and presents them to the core with a valid/ready handshake, each tagged with its PC.
- Accepts a redirect (branch/jump target) from the core, flushes buffered instructions and discards in-flight responses.

Parameters:
DEPTH, 4, prefetch FIFO entries and max in-flight requests; power of 2, >=2
RESET_PC, 32'h00000000, first fetch address after reset

Ports:
clk  input  1  clock
rst  input  1  reset
redirect_valid  input  1  core requests fetch restart at redirect_pc
redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0)
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch word address (bits [1:0] always 0)
imem_gnt  input  1  memory accepts request this cycle (req&&gnt = issued)
imem_rvalid  input  1  response valid; responses return in issue order, >=1 cycle after grant
imem_rdata  input  32  response instruction word
instr_valid  output  1  FIFO head valid
instr  output  32  FIFO head instruction
instr_pc  output  32  PC of FIFO head
instr_ready  input  1  core consumes head (pop when valid&&ready)

Behaviour:
- Interface reset/clock: reset rst, asynchronous, active-high; clock clk.
- Reset values (async):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC
  - FIFO count=0, rd/wr ptrs=0
  - inflight=0, discard=0
  - imem_req=0, instr_valid=0, instr=0, instr_pc=0
- State: fetch_pc (next address to request), resp_pc (PC of next live response), inflight (granted, not yet responded; width clog2(DEPTH)+1), discard (in-flight responses to drop), FIFO of {pc, instr}.
- Request:
  - imem_req = !redirect_valid && (inflight + count < DEPTH); combinational from registers plus redirect_valid.
  - imem_addr = fetch_pc.
  - On req&&gnt: fetch_pc += 4, wrapping at 2^32.
  - Request may be withdrawn without grant; the memory samples only on req&&gnt.
  - A pop in the same cycle does not free credit until the next cycle.
- Response (imem_rvalid):
  - If discard>0: discard-1, data dropped, resp_pc unchanged.
  - Else: push {resp_pc, imem_rdata}, resp_pc += 4.
  - Credit guarantees the FIFO never overflows. A push with a full FIFO is a fatal assertion in simulation.
- inflight_next = inflight + (req&&gnt) - rvalid.
- Output: instr_valid = (count!=0). instr and instr_pc come from the FIFO head registers, stable while valid && !ready. Pop on valid&&ready.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push into an empty FIFO: visible at instr_valid the next cycle (1-cycle rvalid-to-valid latency).
- Redirect (redirect_valid=1), all effects at the next edge:
  - FIFO cleared (count=0, ptrs=0); a pop in the same cycle is ignored.
  - fetch_pc = resp_pc = {redirect_pc[31:2],2'b00}.
  - discard = inflight_next, which includes any response arriving this cycle; that response is dropped.
  - imem_req is forced 0 this cycle, so no grant can occur.
  - Fetch resumes the next cycle if credit allows.
  - Back-to-back redirects: the last one wins; discard accumulates correctly via inflight_next.
- Zero-latency guarantee: first request after reset release is on the first clk edge after rst deasserts, at RESET_PC.
- Reset mid-operation: all state cleared immediately. The memory bus must also be reset, so in-flight responses are not expected after reset.

Optional Feature:
Macro IFETCH_PERF_EN.
- Defined: adds output ports perf_fetch_cnt[31:0], perf_stall_cnt[31:0], perf_flush_cnt[31:0], all reset to 0 and wrapping.
  - perf_fetch_cnt: +1 per req&&gnt.
  - perf_stall_cnt: +1 per cycle with instr_ready=1 && instr_valid=0 && !redirect_valid.
  - perf_flush_cnt: +1 per dropped response, whether dropped via discard or by a same-cycle redirect.
- Undefined: ports and counters are absent; functional behaviour is identical.

Test Plan:
- Streaming: release reset, gnt=1 always, 1-cycle rvalid latency, ready=1 -> imem_addr 0x0,0x4,0x8...; instr_pc 0x0,0x4,0x8 in order with matching data; steady state one instr/cycle.
- Backpressure: DEPTH=4, ready=0 -> exactly 4 grants, then imem_req=0; FIFO full holding PCs 0x0..0xC. Raise ready -> one fetch per pop resumes at 0x10.
- Redirect with 3 in flight (3-cycle rvalid latency), redirect_pc=0x103 -> next request addr 0x100; 3 stale responses dropped; first instr_valid has instr_pc=0x100.
- Redirect coincident with rvalid and pop: FIFO holds 2 entries -> FIFO empty next cycle; the arriving response is dropped; no spurious instr_valid.
- Grant stall: gnt=0 for 5 cycles with req high -> imem_addr stable at 0x0; no fetch_pc advance. gnt=1 -> single issue of 0x0.
- Async reset mid-stream: assert rst between edges -> imem_req=0 and instr_valid=0 immediately. After release, fetch restarts at RESET_PC; with IFETCH_PERF_EN, counters read 0.
